// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - retire-trace capture FIFO with counters and watchdog
//
// Purpose:
//   Classifies each retired instruction (NOP, REG, LOAD, STORE, HALT) and tags it
//   with a 0-based instruction number. Records are queued in a DEPTH-entry FIFO
//   and drained over a valid/ready port. The unit also keeps instruction, cycle
//   and drop counters and a runaway-cycle watchdog.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cm_valid .. cm_halt        retire-side inputs (one instruction per cycle max)
//   trc_valid, trc_ready       head-of-FIFO handshake
//   trc_kind/inum/pc/reg/data/addr   head record fields
//   level                      FIFO occupancy
//   inst_count, cycle_count, drop_count   saturating counters
//   overflow, halted, timeout, done       status flags
module commit_trace_buffer #(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 4,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cm_valid,
    input  logic [DATA_W-1:0]          cm_pc,
    input  logic                       cm_regwrite,
    input  logic [REG_AW-1:0]          cm_wreg,
    input  logic [DATA_W-1:0]          cm_wdata,
    input  logic                       cm_memread,
    input  logic                       cm_memwrite,
    input  logic [DATA_W-1:0]          cm_addr,
    input  logic [DATA_W-1:0]          cm_mdata,
    input  logic                       cm_halt,
    output logic                       trc_valid,
    input  logic                       trc_ready,
    output logic [2:0]                 trc_kind,
    output logic [CNT_W-1:0]           trc_inum,
    output logic [DATA_W-1:0]          trc_pc,
    output logic [REG_AW-1:0]          trc_reg,
    output logic [DATA_W-1:0]          trc_data,
    output logic [DATA_W-1:0]          trc_addr,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           inst_count,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [CNT_W-1:0]           drop_count,
    output logic                       overflow,
    output logic                       halted,
    output logic                       timeout,
    output logic                       done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [2:0] K_NOP   = 3'd0;
    localparam logic [2:0] K_REG   = 3'd1;
    localparam logic [2:0] K_LOAD  = 3'd2;
    localparam logic [2:0] K_STORE = 3'd3;
    localparam logic [2:0] K_HALT  = 3'd4;

    localparam logic [LVL_W-1:0] L_FULL    = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] L_NORMAL  = LVL_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CYCLE_LIMIT - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    state_t               r_state;
    logic                 r_halted;
    logic                 r_timeout;
    logic                 r_overflow;
    logic [CNT_W-1:0]     r_inst_count;
    logic [CNT_W-1:0]     r_cycle_count;
    logic [CNT_W-1:0]     r_drop_count;
    logic [LVL_W-1:0]     r_level;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;

    logic [2:0]           r_mem_kind [DEPTH];
    logic [CNT_W-1:0]     r_mem_inum [DEPTH];
    logic [DATA_W-1:0]    r_mem_pc   [DEPTH];
    logic [REG_AW-1:0]    r_mem_reg  [DEPTH];
    logic [DATA_W-1:0]    r_mem_data [DEPTH];
    logic [DATA_W-1:0]    r_mem_addr [DEPTH];

    logic [2:0]           w_kind;
    logic [REG_AW-1:0]    w_reg;
    logic [DATA_W-1:0]    w_data;
    logic [DATA_W-1:0]    w_addr;
    logic                 w_take;
    logic                 w_pop;
    logic [LVL_W-1:0]     w_limit;
    logic                 w_push;
    logic                 w_drop;

    // Classification: a register write wins over halt, halt over store.
    always_comb begin
        w_kind = K_NOP;
        w_reg  = '0;
        w_data = '0;
        w_addr = '0;
        if (cm_regwrite) begin
            w_kind = cm_memread ? K_LOAD : K_REG;
            w_reg  = cm_wreg;
            w_data = cm_wdata;
            w_addr = cm_memread ? cm_addr : '0;
        end else if (cm_halt) begin
            w_kind = K_HALT;
        end else if (cm_memwrite) begin
            w_kind = K_STORE;
            w_addr = cm_addr;
            w_data = cm_mdata;
        end
    end

    // The last FIFO slot is kept for the HALT record so it can never be lost;
    // a push at the limit still fits if the head leaves on the same edge.
    always_comb begin
        w_take  = cm_valid && (r_state == S_RUN);
        w_pop   = (r_level != '0) && trc_ready;
        w_limit = (w_kind == K_HALT) ? L_FULL : L_NORMAL;
        w_push  = w_take && ((r_level < w_limit) || ((r_level == w_limit) && w_pop));
        w_drop  = w_take && !w_push;
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_kind[r_wr_ptr] <= w_kind;
            r_mem_inum[r_wr_ptr] <= r_inst_count;
            r_mem_pc[r_wr_ptr]   <= cm_pc;
            r_mem_reg[r_wr_ptr]  <= w_reg;
            r_mem_data[r_wr_ptr] <= w_data;
            r_mem_addr[r_wr_ptr] <= w_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_halted      <= 1'b0;
            r_timeout     <= 1'b0;
            r_overflow    <= 1'b0;
            r_inst_count  <= '0;
            r_cycle_count <= '0;
            r_drop_count  <= '0;
            r_level       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);

            if (w_take && (r_inst_count != CNT_MAX)) begin
                r_inst_count <= r_inst_count + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != CNT_MAX) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end

            case (r_state)
                S_RUN: begin
                    if (r_cycle_count != CNT_MAX) begin
                        r_cycle_count <= r_cycle_count + 1'b1;
                    end
                    if (cm_valid && cm_halt) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end else if (r_cycle_count == CYC_LAST) begin
                        r_state   <= S_TIMEOUT;
                        r_timeout <= 1'b1;
                    end
                end
                S_HALTED:  r_state <= S_HALTED;
                S_TIMEOUT: r_state <= S_TIMEOUT;
                default:   r_state <= S_RUN;
            endcase
        end
    end

    assign trc_valid   = (r_level != '0);
    assign trc_kind    = r_mem_kind[r_rd_ptr];
    assign trc_inum    = r_mem_inum[r_rd_ptr];
    assign trc_pc      = r_mem_pc[r_rd_ptr];
    assign trc_reg     = r_mem_reg[r_rd_ptr];
    assign trc_data    = r_mem_data[r_rd_ptr];
    assign trc_addr    = r_mem_addr[r_rd_ptr];
    assign level       = r_level;
    assign inst_count  = r_inst_count;
    assign cycle_count = r_cycle_count;
    assign drop_count  = r_drop_count;
    assign overflow    = r_overflow;
    assign halted      = r_halted;
    assign timeout     = r_timeout;
    assign done        = (r_halted || r_timeout) && (r_level == '0);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - scoreboard bench for commit_trace_buffer
module tb_commit_trace_buffer;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 32;
    localparam int LIMIT  = 50;

    logic              clk;
    logic              rst_n;
    logic              cm_valid;
    logic [DATA_W-1:0] cm_pc;
    logic              cm_regwrite;
    logic [REG_AW-1:0] cm_wreg;
    logic [DATA_W-1:0] cm_wdata;
    logic              cm_memread;
    logic              cm_memwrite;
    logic [DATA_W-1:0] cm_addr;
    logic [DATA_W-1:0] cm_mdata;
    logic              cm_halt;
    logic              trc_valid;
    logic              trc_ready;
    logic [2:0]        trc_kind;
    logic [CNT_W-1:0]  trc_inum;
    logic [DATA_W-1:0] trc_pc;
    logic [REG_AW-1:0] trc_reg;
    logic [DATA_W-1:0] trc_data;
    logic [DATA_W-1:0] trc_addr;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]  inst_count;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  drop_count;
    logic              overflow;
    logic              halted;
    logic              timeout;
    logic              done;

    commit_trace_buffer #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W), .CYCLE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_regwrite(cm_regwrite), .cm_wreg(cm_wreg),
        .cm_wdata(cm_wdata), .cm_memread(cm_memread), .cm_memwrite(cm_memwrite),
        .cm_addr(cm_addr), .cm_mdata(cm_mdata), .cm_halt(cm_halt),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_kind(trc_kind), .trc_inum(trc_inum),
        .trc_pc(trc_pc), .trc_reg(trc_reg), .trc_data(trc_data), .trc_addr(trc_addr),
        .level(level), .inst_count(inst_count), .cycle_count(cycle_count),
        .drop_count(drop_count), .overflow(overflow), .halted(halted),
        .timeout(timeout), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]        kind;
        logic [CNT_W-1:0]  inum;
        logic [DATA_W-1:0] pc;
        logic [REG_AW-1:0] rg;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] addr;
    } rec_t;

    rec_t expq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: 0 run, 1 halted, 2 timed out
    int      m_state;
    longint  m_inst, m_cycle, m_drop;
    int      m_level;
    bit      m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        expq.delete();
        m_state = 0;
        m_inst  = 0;
        m_cycle = 0;
        m_drop  = 0;
        m_level = 0;
        m_ovf   = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cm_valid = 0; cm_pc = 0; cm_regwrite = 0; cm_wreg = 0; cm_wdata = 0;
        cm_memread = 0; cm_memwrite = 0; cm_addr = 0; cm_mdata = 0; cm_halt = 0;
        trc_ready = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    // Drive one cycle of inputs, advance the model to what the next edge should do.
    task automatic step(input bit v, input logic [15:0] pc, input bit rw, input logic [3:0] wreg,
                        input logic [15:0] wdata, input bit mr, input bit mw,
                        input logic [15:0] addr, input logic [15:0] mdata,
                        input bit hlt, input bit rdy);
        bit   pop;
        bit   push;
        int   cap;
        rec_t r;
        cm_valid = v; cm_pc = pc; cm_regwrite = rw; cm_wreg = wreg; cm_wdata = wdata;
        cm_memread = mr; cm_memwrite = mw; cm_addr = addr; cm_mdata = mdata;
        cm_halt = hlt; trc_ready = rdy;

        pop  = (m_level > 0) && rdy;
        push = 0;
        if (m_state == 0) begin
            if (v) begin
                r.pc = pc; r.rg = '0; r.data = '0; r.addr = '0;
                r.inum = m_inst[CNT_W-1:0];
                if (rw) begin
                    r.kind = mr ? 3'd2 : 3'd1;
                    r.rg   = wreg;
                    r.data = wdata;
                    if (mr) r.addr = addr;
                end else if (hlt) begin
                    r.kind = 3'd4;
                end else if (mw) begin
                    r.kind = 3'd3;
                    r.addr = addr;
                    r.data = mdata;
                end else begin
                    r.kind = 3'd0;
                end
                cap = (r.kind == 3'd4) ? DEPTH : DEPTH - 1;
                if (m_level < cap || (m_level == cap && pop)) begin
                    expq.push_back(r);
                    push = 1;
                end else begin
                    m_drop++;
                    m_ovf = 1;
                end
                if (m_inst < 64'hFFFF_FFFF) m_inst++;
            end
            if (v && hlt) m_state = 1;
            else if (m_cycle == LIMIT - 1) m_state = 2;
            if (m_cycle < 64'hFFFF_FFFF) m_cycle++;
        end
        m_level = m_level + int'(push) - int'(pop);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input bit rdy);
        step(1, 16'($urandom), 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic halt_at(input logic [15:0] pc, input bit rdy);
        step(1, pc, 0, 0, 0, 0, 0, 0, 0, 1, rdy);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) idle(1);
        chk("drain_queue_empty", 64'(expq.size()), 64'd0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_inst"},  64'(inst_count),  64'(m_inst));
        chk({tag, "_cycle"}, 64'(cycle_count), 64'(m_cycle));
        chk({tag, "_drop"},  64'(drop_count),  64'(m_drop));
        chk({tag, "_ovf"},   64'(overflow),    64'(m_ovf));
        chk({tag, "_level"}, 64'(level),       64'(m_level));
        chk({tag, "_halt"},  64'(halted),      64'(m_state == 1));
        chk({tag, "_tmo"},   64'(timeout),     64'(m_state == 2));
        chk({tag, "_done"},  64'(done),        64'((m_state != 0) && (m_level == 0)));
    endtask

    // Monitor: every accepted head record is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && trc_valid && trc_ready) begin
            if (expq.size() == 0) begin
                chk("rec_unexpected", 64'(trc_inum), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                rec_t e;
                e = expq.pop_front();
                chk("rec_kind", 64'(trc_kind), 64'(e.kind));
                chk("rec_inum", 64'(trc_inum), 64'(e.inum));
                chk("rec_pc",   64'(trc_pc),   64'(e.pc));
                chk("rec_reg",  64'(trc_reg),  64'(e.rg));
                chk("rec_data", 64'(trc_data), 64'(e.data));
                chk("rec_addr", 64'(trc_addr), 64'(e.addr));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        model_clear();

        // Reset state
        do_reset();
        chk("rst_valid", 64'(trc_valid), 0);
        chk("rst_level", 64'(level), 0);
        chk("rst_inst",  64'(inst_count), 0);
        chk("rst_cycle", 64'(cycle_count), 0);
        chk("rst_drop",  64'(drop_count), 0);
        chk("rst_flags", 64'({overflow, halted, timeout, done}), 0);

        // 1) register write then HALT
        step(1, 16'h0000, 1, 4'd3, 16'h0005, 0, 0, 16'h0, 16'h0, 0, 1);
        halt_at(16'h0002, 1);
        drain(4);
        chk("t1_halted", 64'(halted), 1);
        chk("t1_done",   64'(done), 1);
        check_model("t1");

        // 2) LOAD then STORE
        do_reset();
        step(1, 16'h0004, 1, 4'd1, 16'hBEEF, 1, 0, 16'h0010, 16'h0, 0, 1);
        step(1, 16'h0006, 0, 4'd0, 16'h0, 0, 1, 16'h0012, 16'h1234, 0, 1);
        chk("t2_inst", 64'(inst_count), 2);
        drain(4);
        check_model("t2");

        // 3) overflow, then HALT uses the reserved slot
        do_reset();
        for (int i = 0; i < 20; i++) nop(0);
        chk("t3_level",    64'(level), 15);
        chk("t3_drop",     64'(drop_count), 5);
        chk("t3_overflow", 64'(overflow), 1);
        halt_at(16'h0100, 0);
        chk("t3_level_halt", 64'(level), 16);
        drain(20);
        chk("t3_done", 64'(done), 1);
        check_model("t3");

        // 4) steady push+pop at DEPTH-1 across pointer wrap
        do_reset();
        for (int i = 0; i < 15; i++) nop(0);
        for (int i = 0; i < 10; i++) begin
            nop(1);
            chk("t4_level", 64'(level), 15);
        end
        chk("t4_drop", 64'(drop_count), 0);
        halt_at(16'h0200, 1);
        drain(20);
        check_model("t4");

        // 5) watchdog
        do_reset();
        for (int i = 0; i < LIMIT - 1; i++) nop(1);
        chk("t5_no_tmo_yet", 64'(timeout), 0);
        nop(1);
        chk("t5_timeout", 64'(timeout), 1);
        chk("t5_cycle",   64'(cycle_count), 50);
        for (int i = 0; i < 5; i++) nop(1);
        chk("t5_inst_frozen",  64'(inst_count), 50);
        chk("t5_cycle_frozen", 64'(cycle_count), 50);
        drain(4);
        check_model("t5");

        // 6) reset mid-run
        do_reset();
        for (int i = 0; i < 7; i++) nop(0);
        chk("t6_level_pre", 64'(level), 7);
        do_reset();
        chk("t6_level", 64'(level), 0);
        chk("t6_valid", 64'(trc_valid), 0);
        chk("t6_inst",  64'(inst_count), 0);
        chk("t6_cycle", 64'(cycle_count), 0);
        chk("t6_drop",  64'(drop_count), 0);

        // Randomized runs; odd runs starve the consumer to force drops
        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int c = 0; c < 70; c++) begin
                bit v, rw, mr, mw, h, rdy;
                v   = ($urandom_range(0, 9) < 7);
                rw  = ($urandom_range(0, 2) == 0);
                mr  = $urandom_range(0, 1) == 1;
                mw  = $urandom_range(0, 1) == 1;
                h   = ($urandom_range(0, 44) == 0);
                if (h) rw = 0;
                rdy = (it % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
                step(v, 16'($urandom), rw, 4'($urandom), 16'($urandom), mr, mw,
                     16'($urandom), 16'($urandom), h, rdy);
            end
            drain(20);
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
